cb_arbiter_2x1: RTL and testbench

- Shares one core data bus slave port between two core-bus masters: M0 (LSU data port) and M1 (debug/DMA or second requester).
- Arbitrates the read-address and write-address channels independently.
- Records each granted address in per-direction order FIFOs, which route write data, read data and write responses to the owning master.
- Sits between the masters and the interconnect; all channels keep the s_cb_mosi_t / s_cb_miso_t valid/ready semantics.

---
 rtl/cb_arbiter_2x1.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_cb_arbiter_2x1.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// cb_arbiter_2x1
//
// Shares one core-bus slave port between two masters (M0 = LSU data port,
// M1 = debug/DMA or a second requester). The read-address and write-address
// channels are arbitrated independently. Every granted address records its
// master index in a per-direction order FIFO. Those FIFOs steer write data,
// read data and write responses back to the owning master, in grant order.
//
// Configuration macro:
//   CB_ARB_FIXED_PRIO_EN  defined   -> M0 always wins simultaneous requests
//                         undefined -> round-robin, first favoured = RR_INIT
//
// Parameters:
//   OT_DEPTH  outstanding transactions per direction (power of 2, >= 1)
//   RR_INIT   master index favoured first after reset
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   m0_mosi_i  master 0 request channels
//   m0_miso_o  master 0 response channels
//   m1_mosi_i  master 1 request channels
//   m1_miso_o  master 1 response channels
//   s_mosi_o   shared slave request channels
//   s_miso_i   shared slave response channels
//   arb_err_o  sticky: slave response arrived with an empty order FIFO
// -----------------------------------------------------------------------------
package cb_arbiter_2x1_pkg;

    typedef struct packed {
        logic        rd_addr_valid;
        logic [31:0] rd_addr;
        logic [1:0]  rd_size;
        logic        rd_ready;
        logic        wr_addr_valid;
        logic [31:0] wr_addr;
        logic [1:0]  wr_size;
        logic        wr_data_valid;
        logic [31:0] wr_data;
        logic [3:0]  wr_strobe;
        logic        wr_resp_ready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic        rd_addr_ready;
        logic        rd_valid;
        logic [31:0] rd_data;
        logic [1:0]  rd_resp;
        logic        wr_addr_ready;
        logic        wr_data_ready;
        logic        wr_resp_valid;
        logic        wr_resp_error;
    } s_cb_miso_t;

endpackage

module cb_arbiter_2x1
    import cb_arbiter_2x1_pkg::*;
#(
    parameter int OT_DEPTH = 2,
    parameter int RR_INIT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  s_cb_mosi_t m0_mosi_i,
    output s_cb_miso_t m0_miso_o,
    input  s_cb_mosi_t m1_mosi_i,
    output s_cb_miso_t m1_miso_o,
    output s_cb_mosi_t s_mosi_o,
    input  s_cb_miso_t s_miso_i,
    output logic       arb_err_o
);

    localparam int PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OT_DEPTH + 1);

    // Order FIFO slots: read order, write-data order, write-response order.
    localparam int F_RD = 0;
    localparam int F_WD = 1;
    localparam int F_WR = 2;

    // Masters as arrays so every routing decision is a simple index.
    s_cb_mosi_t m_mosi [2];
    s_cb_miso_t m_miso [2];

    assign m_mosi[0] = m0_mosi_i;
    assign m_mosi[1] = m1_mosi_i;
    assign m0_miso_o = m_miso[0];
    assign m1_miso_o = m_miso[1];

    // -------------------------------------------------------------------------
    // Order FIFOs (three instances of a 1-bit-wide queue of master indices)
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wptr_q [3];
    logic [PTR_W-1:0] rptr_q [3];
    logic [CNT_W-1:0] cnt_q  [3];
    logic             mem_q  [3][OT_DEPTH];

    logic [2:0] fifo_push;
    logic [2:0] fifo_pop;
    logic [2:0] fifo_in;
    logic [2:0] fifo_head;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int f = 0; f < 3; f++) begin
            fifo_head[f]  = mem_q[f][rptr_q[f]];
            fifo_empty[f] = (cnt_q[f] == '0);
            fifo_full[f]  = (cnt_q[f] == CNT_W'(OT_DEPTH));
        end
    end

    // Pushes are only ever requested when the FIFO has room (address and
    // write-data handshakes are gated by the full flags), so no overflow guard.
    always_ff @(posedge clk) begin
        for (int f = 0; f < 3; f++) begin
            if (rst) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // register samples its inputs from the same pre-edge values.
                wptr_q[f] <= '0;
                rptr_q[f] <= '0;
                cnt_q[f]  <= '0;
            end else begin
                if (fifo_push[f]) wptr_q[f] <= ptr_inc(wptr_q[f]);
                if (fifo_pop[f])  rptr_q[f] <= ptr_inc(rptr_q[f]);
                case ({fifo_push[f], fifo_pop[f]})
                    2'b10:   cnt_q[f] <= cnt_q[f] + CNT_W'(1);
                    2'b01:   cnt_q[f] <= cnt_q[f] - CNT_W'(1);
                    default: cnt_q[f] <= cnt_q[f];
                endcase
            end
        end
    end

    // NOTE: the storage is deliberately not reset; a slot is only read after it
    // has been written, and the pointers/counts above carry the reset meaning.
    always_ff @(posedge clk) begin
        for (int f = 0; f < 3; f++) begin
            if (fifo_push[f]) mem_q[f][wptr_q[f]] <= fifo_in[f];
        end
    end

    // -------------------------------------------------------------------------
    // Address arbitration (read and write channels are independent)
    // -------------------------------------------------------------------------
    logic rd_prio, wr_prio;           // master favoured on a tie
    logic rd_lock_q, wr_lock_q;
    logic rd_owner_q, wr_owner_q;
    logic rd_lock_eff, wr_lock_eff;
    logic rd_any, wr_any;
    logic rd_gnt, wr_gnt;
    logic rd_fwd, wr_fwd;
    logic rd_hs, wr_hs;

    function automatic logic arb_pick(input logic v0, input logic v1,
                                      input logic locked, input logic owner,
                                      input logic prio);
        if (locked)   return owner;
        if (v0 && v1) return prio;
        return v1;
    endfunction

    // A lock only holds while its owner keeps valid asserted; dropping valid
    // releases it in the same cycle.
    assign rd_lock_eff = rd_lock_q & m_mosi[rd_owner_q].rd_addr_valid;
    assign wr_lock_eff = wr_lock_q & m_mosi[wr_owner_q].wr_addr_valid;

    assign rd_any = m_mosi[0].rd_addr_valid | m_mosi[1].rd_addr_valid;
    assign wr_any = m_mosi[0].wr_addr_valid | m_mosi[1].wr_addr_valid;

    assign rd_gnt = arb_pick(m_mosi[0].rd_addr_valid, m_mosi[1].rd_addr_valid,
                             rd_lock_eff, rd_owner_q, rd_prio);
    assign wr_gnt = arb_pick(m_mosi[0].wr_addr_valid, m_mosi[1].wr_addr_valid,
                             wr_lock_eff, wr_owner_q, wr_prio);

    // A full order FIFO blocks the address from reaching the slave at all.
    assign rd_fwd = rd_any & ~fifo_full[F_RD];
    assign wr_fwd = wr_any & ~fifo_full[F_WD];
    assign rd_hs  = rd_fwd & s_miso_i.rd_addr_ready;
    assign wr_hs  = wr_fwd & s_miso_i.wr_addr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lock_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            wr_lock_q  <= 1'b0;
            wr_owner_q <= 1'b0;
        end else begin
            // Lock whenever the slave saw a valid address but did not take it.
            rd_lock_q  <= rd_fwd & ~s_miso_i.rd_addr_ready;
            rd_owner_q <= rd_gnt;
            wr_lock_q  <= wr_fwd & ~s_miso_i.wr_addr_ready;
            wr_owner_q <= wr_gnt;
        end
    end

`ifdef CB_ARB_FIXED_PRIO_EN
    assign rd_prio = 1'b0;
    assign wr_prio = 1'b0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_prio <= (RR_INIT != 0);
            wr_prio <= (RR_INIT != 0);
        end else begin
            if (rd_hs) rd_prio <= ~rd_gnt;
            if (wr_hs) wr_prio <= ~wr_gnt;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Response-side handshakes and FIFO control
    // -------------------------------------------------------------------------
    logic rd_pop, wd_open, wd_pop, wr_pop;

    assign rd_pop  = s_miso_i.rd_valid & m_mosi[fifo_head[F_RD]].rd_ready
                   & ~fifo_empty[F_RD];
    // Write data may only flow when the response FIFO can record its owner.
    assign wd_open = ~fifo_empty[F_WD] & ~fifo_full[F_WR];
    assign wd_pop  = wd_open & m_mosi[fifo_head[F_WD]].wr_data_valid
                   & s_miso_i.wr_data_ready;
    assign wr_pop  = s_miso_i.wr_resp_valid & m_mosi[fifo_head[F_WR]].wr_resp_ready
                   & ~fifo_empty[F_WR];

    assign fifo_push = {wd_pop, wr_hs, rd_hs};
    assign fifo_pop  = {wr_pop, wd_pop, rd_pop};
    assign fifo_in   = {fifo_head[F_WD], wr_gnt, rd_gnt};

    // -------------------------------------------------------------------------
    // Output routing (all zero-latency)
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        s_mosi_o  = '0;
        m_miso[0] = '0;
        m_miso[1] = '0;

        if (rd_any) begin
            s_mosi_o.rd_addr_valid        = rd_fwd;
            s_mosi_o.rd_addr              = m_mosi[rd_gnt].rd_addr;
            s_mosi_o.rd_size              = m_mosi[rd_gnt].rd_size;
            m_miso[rd_gnt].rd_addr_ready  = s_miso_i.rd_addr_ready & ~fifo_full[F_RD];
        end

        if (wr_any) begin
            s_mosi_o.wr_addr_valid        = wr_fwd;
            s_mosi_o.wr_addr              = m_mosi[wr_gnt].wr_addr;
            s_mosi_o.wr_size              = m_mosi[wr_gnt].wr_size;
            m_miso[wr_gnt].wr_addr_ready  = s_miso_i.wr_addr_ready & ~fifo_full[F_WD];
        end

        // Orphan responses (empty FIFO) are accepted and dropped.
        if (!fifo_empty[F_RD]) begin
            m_miso[fifo_head[F_RD]].rd_valid = s_miso_i.rd_valid;
            m_miso[fifo_head[F_RD]].rd_data  = s_miso_i.rd_data;
            m_miso[fifo_head[F_RD]].rd_resp  = s_miso_i.rd_resp;
            s_mosi_o.rd_ready                = m_mosi[fifo_head[F_RD]].rd_ready;
        end else begin
            s_mosi_o.rd_ready = 1'b1;
        end

        if (wd_open) begin
            s_mosi_o.wr_data_valid                = m_mosi[fifo_head[F_WD]].wr_data_valid;
            s_mosi_o.wr_data                      = m_mosi[fifo_head[F_WD]].wr_data;
            s_mosi_o.wr_strobe                    = m_mosi[fifo_head[F_WD]].wr_strobe;
            m_miso[fifo_head[F_WD]].wr_data_ready = s_miso_i.wr_data_ready;
        end

        if (!fifo_empty[F_WR]) begin
            m_miso[fifo_head[F_WR]].wr_resp_valid = s_miso_i.wr_resp_valid;
            m_miso[fifo_head[F_WR]].wr_resp_error = s_miso_i.wr_resp_error;
            s_mosi_o.wr_resp_ready                = m_mosi[fifo_head[F_WR]].wr_resp_ready;
        end else begin
            s_mosi_o.wr_resp_ready = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky orphan-response flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_err_o <= 1'b0;
        end else if ((s_miso_i.rd_valid & fifo_empty[F_RD]) |
                     (s_miso_i.wr_resp_valid & fifo_empty[F_WR])) begin
            arb_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cb_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// Bench for cb_arbiter_2x1 (default parameters: OT_DEPTH = 2, RR_INIT = 0).
// Stimulus pushes expected beats into per-channel queues; a negedge monitor
// pops and compares on every handshake. Cycle-specific properties (grants,
// readies, routing exclusivity, error flag) are checked inline.
// -----------------------------------------------------------------------------
module tb_cb_arbiter_2x1;
    import cb_arbiter_2x1_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    s_cb_mosi_t m0_mosi, m1_mosi, s_mosi;
    s_cb_miso_t m0_miso, m1_miso, s_miso;
    logic       arb_err;

    always #5 clk = ~clk;

    cb_arbiter_2x1 dut (
        .clk       (clk),
        .rst       (rst),
        .m0_mosi_i (m0_mosi),
        .m0_miso_o (m0_miso),
        .m1_mosi_i (m1_mosi),
        .m1_miso_o (m1_miso),
        .s_mosi_o  (s_mosi),
        .s_miso_i  (s_miso),
        .arb_err_o (arb_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_s_rd_addr [$];
    logic [31:0] q_s_wr_addr [$];
    logic [31:0] q_s_wr_data [$];
    logic [31:0] q_m0_rd     [$];
    logic [31:0] q_m1_rd     [$];
    logic [31:0] q_m0_wresp  [$];
    logic [31:0] q_m1_wresp  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected beat 0x%0h, none required", name, act);
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_mosi.rd_addr_valid && s_miso.rd_addr_ready) begin
                if (q_s_rd_addr.size() == 0) unexpected("s_rd_addr", s_mosi.rd_addr);
                else check("s_rd_addr", s_mosi.rd_addr, q_s_rd_addr.pop_front());
            end
            if (s_mosi.wr_addr_valid && s_miso.wr_addr_ready) begin
                if (q_s_wr_addr.size() == 0) unexpected("s_wr_addr", s_mosi.wr_addr);
                else check("s_wr_addr", s_mosi.wr_addr, q_s_wr_addr.pop_front());
            end
            if (s_mosi.wr_data_valid && s_miso.wr_data_ready) begin
                if (q_s_wr_data.size() == 0) unexpected("s_wr_data", s_mosi.wr_data);
                else check("s_wr_data", s_mosi.wr_data, q_s_wr_data.pop_front());
            end
            if (m0_miso.rd_valid && m0_mosi.rd_ready) begin
                if (q_m0_rd.size() == 0) unexpected("m0_rd_data", m0_miso.rd_data);
                else check("m0_rd_data", m0_miso.rd_data, q_m0_rd.pop_front());
            end
            if (m1_miso.rd_valid && m1_mosi.rd_ready) begin
                if (q_m1_rd.size() == 0) unexpected("m1_rd_data", m1_miso.rd_data);
                else check("m1_rd_data", m1_miso.rd_data, q_m1_rd.pop_front());
            end
            if (m0_miso.wr_resp_valid && m0_mosi.wr_resp_ready) begin
                if (q_m0_wresp.size() == 0) unexpected("m0_wr_resp", 32'(m0_miso.wr_resp_error));
                else check("m0_wr_resp_err", 32'(m0_miso.wr_resp_error), q_m0_wresp.pop_front());
            end
            if (m1_miso.wr_resp_valid && m1_mosi.wr_resp_ready) begin
                if (q_m1_wresp.size() == 0) unexpected("m1_wr_resp", 32'(m1_miso.wr_resp_error));
                else check("m1_wr_resp_err", 32'(m1_miso.wr_resp_error), q_m1_wresp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_w [5];

        rst     = 1'b1;
        m0_mosi = '0;
        m1_mosi = '0;
        s_miso  = '0;
        m0_mosi.rd_ready      = 1'b1;
        m1_mosi.rd_ready      = 1'b1;
        m0_mosi.wr_resp_ready = 1'b1;
        m1_mosi.wr_resp_ready = 1'b1;
        s_miso.rd_addr_ready  = 1'b1;
        s_miso.wr_addr_ready  = 1'b1;
        s_miso.wr_data_ready  = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        check("rst_s_rd_ready",      32'(s_mosi.rd_ready), 1);
        check("rst_s_wr_resp_ready", 32'(s_mosi.wr_resp_ready), 1);
        check("rst_s_valids",        32'({s_mosi.rd_addr_valid, s_mosi.wr_addr_valid, s_mosi.wr_data_valid}), 0);
        check("rst_m0_miso_zero",    32'(m0_miso == '0), 1);
        check("rst_m1_miso_zero",    32'(m1_miso == '0), 1);
        check("rst_arb_err",         32'(arb_err), 0);
        cyc();
        rst = 1'b0;

        // ---------------- simultaneous reads, RR ----------------
        m0_mosi.rd_addr_valid = 1'b1; m0_mosi.rd_addr = 32'h100;
        m1_mosi.rd_addr_valid = 1'b1; m1_mosi.rd_addr = 32'h200;
        q_s_rd_addr.push_back(32'h100);
        q_s_rd_addr.push_back(32'h200);
        #1;
        check("t1_c0_m0_rdy",  32'(m0_miso.rd_addr_ready), 1);
        check("t1_c0_m1_rdy",  32'(m1_miso.rd_addr_ready), 0);
        check("t1_c0_s_addr",  s_mosi.rd_addr, 32'h100);
        cyc();
        m0_mosi.rd_addr_valid = 1'b0;
        #1;
        check("t1_c1_m1_rdy",  32'(m1_miso.rd_addr_ready), 1);
        check("t1_c1_s_addr",  s_mosi.rd_addr, 32'h200);
        cyc();
        m1_mosi.rd_addr_valid = 1'b0;
        q_m0_rd.push_back(32'hAAAA);
        q_m1_rd.push_back(32'hBBBB);
        s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'hAAAA;
        #1;
        check("t1_aaaa_m1_quiet", 32'(m1_miso.rd_valid), 0);
        cyc();
        s_miso.rd_data = 32'hBBBB;
        #1;
        check("t1_bbbb_m0_quiet", 32'(m0_miso.rd_valid), 0);
        cyc();
        s_miso.rd_valid = 1'b0;

        // ---------------- lock while slave stalls ----------------
        s_miso.rd_addr_ready  = 1'b0;
        m1_mosi.rd_addr_valid = 1'b1; m1_mosi.rd_addr = 32'h300;
        q_s_rd_addr.push_back(32'h300);
        q_s_rd_addr.push_back(32'h400);
        #1;
        check("t2_c0_s_addr", s_mosi.rd_addr, 32'h300);
        check("t2_c0_m1_rdy", 32'(m1_miso.rd_addr_ready), 0);
        cyc();
        m0_mosi.rd_addr_valid = 1'b1; m0_mosi.rd_addr = 32'h400;
        #1;
        check("t2_c1_s_addr", s_mosi.rd_addr, 32'h300);
        check("t2_c1_m0_rdy", 32'(m0_miso.rd_addr_ready), 0);
        cyc();
        #1;
        check("t2_c2_s_addr", s_mosi.rd_addr, 32'h300);
        cyc();
        s_miso.rd_addr_ready = 1'b1;
        #1;
        check("t2_c3_s_addr", s_mosi.rd_addr, 32'h300);
        check("t2_c3_m1_rdy", 32'(m1_miso.rd_addr_ready), 1);
        check("t2_c3_m0_rdy", 32'(m0_miso.rd_addr_ready), 0);
        cyc();
        m1_mosi.rd_addr_valid = 1'b0;
        #1;
        check("t2_c4_s_addr", s_mosi.rd_addr, 32'h400);
        check("t2_c4_m0_rdy", 32'(m0_miso.rd_addr_ready), 1);
        cyc();
        m0_mosi.rd_addr_valid = 1'b0;
        q_m1_rd.push_back(32'h3333);
        q_m0_rd.push_back(32'h4444);
        s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'h3333;
        cyc();
        s_miso.rd_data = 32'h4444;
        cyc();
        s_miso.rd_valid = 1'b0;

        // ---------------- outstanding limit ----------------
        m0_mosi.rd_addr_valid = 1'b1; m0_mosi.rd_addr = 32'h500;
        q_s_rd_addr.push_back(32'h500);
        cyc();
        m0_mosi.rd_addr = 32'h504;
        q_s_rd_addr.push_back(32'h504);
        cyc();
        m0_mosi.rd_addr = 32'h508;
        #1;
        check("t3_full_m0_rdy",  32'(m0_miso.rd_addr_ready), 0);
        check("t3_full_s_valid", 32'(s_mosi.rd_addr_valid), 0);
        cyc();
        #1;
        check("t3_full2_s_valid", 32'(s_mosi.rd_addr_valid), 0);
        cyc();
        q_m0_rd.push_back(32'h5500);
        s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'h5500;
        #1;
        check("t3_pop_cyc_s_valid", 32'(s_mosi.rd_addr_valid), 0);
        cyc();
        s_miso.rd_valid = 1'b0;
        q_s_rd_addr.push_back(32'h508);
        #1;
        check("t3_after_pop_s_valid", 32'(s_mosi.rd_addr_valid), 1);
        check("t3_after_pop_s_addr",  s_mosi.rd_addr, 32'h508);
        check("t3_after_pop_m0_rdy",  32'(m0_miso.rd_addr_ready), 1);
        cyc();
        m0_mosi.rd_addr_valid = 1'b0;
        q_m0_rd.push_back(32'h5504);
        q_m0_rd.push_back(32'h5508);
        s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'h5504;
        cyc();
        s_miso.rd_data = 32'h5508;
        cyc();
        s_miso.rd_valid = 1'b0;

        // ---------------- write interleave ----------------
        m0_mosi.wr_addr_valid = 1'b1; m0_mosi.wr_addr = 32'h600;
        q_s_wr_addr.push_back(32'h600);
        cyc();
        m0_mosi.wr_addr_valid = 1'b0;
        m1_mosi.wr_addr_valid = 1'b1; m1_mosi.wr_addr = 32'h700;
        m1_mosi.wr_data_valid = 1'b1; m1_mosi.wr_data = 32'h77; m1_mosi.wr_strobe = 4'hF;
        q_s_wr_addr.push_back(32'h700);
        #1;
        check("t4_c1_m1_wdrdy",  32'(m1_miso.wr_data_ready), 0);
        check("t4_c1_s_wdvalid", 32'(s_mosi.wr_data_valid), 0);
        cyc();
        m1_mosi.wr_addr_valid = 1'b0;
        #1;
        check("t4_c2_m1_wdrdy", 32'(m1_miso.wr_data_ready), 0);
        cyc();
        m0_mosi.wr_data_valid = 1'b1; m0_mosi.wr_data = 32'h66; m0_mosi.wr_strobe = 4'hF;
        q_s_wr_data.push_back(32'h66);
        q_s_wr_data.push_back(32'h77);
        #1;
        check("t4_c3_m0_wdrdy", 32'(m0_miso.wr_data_ready), 1);
        check("t4_c3_m1_wdrdy", 32'(m1_miso.wr_data_ready), 0);
        cyc();
        m0_mosi.wr_data_valid = 1'b0;
        #1;
        check("t4_c4_m1_wdrdy", 32'(m1_miso.wr_data_ready), 1);
        cyc();
        m1_mosi.wr_data_valid = 1'b0;
        q_m0_wresp.push_back(32'd1);
        q_m1_wresp.push_back(32'd0);
        s_miso.wr_resp_valid = 1'b1; s_miso.wr_resp_error = 1'b1;
        #1;
        check("t4_resp0_m1_quiet", 32'(m1_miso.wr_resp_valid), 0);
        cyc();
        s_miso.wr_resp_error = 1'b0;
        #1;
        check("t4_resp1_m0_quiet", 32'(m0_miso.wr_resp_valid), 0);
        cyc();
        s_miso.wr_resp_valid = 1'b0;

        // ---------------- orphan read response ----------------
        s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'hDEAD;
        #1;
        check("t5_m0_rd_valid", 32'(m0_miso.rd_valid), 0);
        check("t5_m1_rd_valid", 32'(m1_miso.rd_valid), 0);
        check("t5_s_rd_ready",  32'(s_mosi.rd_ready), 1);
        check("t5_err_same_cyc", 32'(arb_err), 0);
        cyc();
        s_miso.rd_valid = 1'b0;
        #1;
        check("t5_err_next_cyc", 32'(arb_err), 1);
        repeat (3) cyc();
        check("t5_err_sticky", 32'(arb_err), 1);

        // ---------------- reset mid-transfer ----------------
        m0_mosi.rd_addr_valid = 1'b1; m0_mosi.rd_addr = 32'hA00;
        q_s_rd_addr.push_back(32'hA00);
        cyc();
        m0_mosi.rd_addr_valid = 1'b0;
        m0_mosi.rd_ready      = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("t6_err_cleared",     32'(arb_err), 0);
        check("t6_rd_fifo_flushed", 32'(s_mosi.rd_ready), 1);
        m0_mosi.rd_ready = 1'b1;

        // ---------------- continuous contention ----------------
        for (int k = 0; k < 5; k++) begin
`ifdef CB_ARB_FIXED_PRIO_EN
            exp_w[k] = (k == 4);
`else
            exp_w[k] = (k == 4) ? 1'b1 : k[0];
`endif
        end
        for (int k = 0; k < 6; k++) begin
            m0_mosi.rd_addr_valid = (k < 4); m0_mosi.rd_addr = 32'h800;
            m1_mosi.rd_addr_valid = (k < 5); m1_mosi.rd_addr = 32'h900;
            s_miso.rd_valid = (k >= 1);
            s_miso.rd_data  = 32'hC000 + 32'(k);
            if (k >= 1) begin
                if (exp_w[k-1]) q_m1_rd.push_back(32'hC000 + 32'(k));
                else            q_m0_rd.push_back(32'hC000 + 32'(k));
            end
            if (k < 5) begin
                q_s_rd_addr.push_back(exp_w[k] ? 32'h900 : 32'h800);
                #1;
                check("t7_grant_addr", s_mosi.rd_addr, exp_w[k] ? 32'h900 : 32'h800);
                check("t7_m1_rdy", 32'(m1_miso.rd_addr_ready), 32'(exp_w[k]));
            end
            cyc();
        end
        m0_mosi.rd_addr_valid = 1'b0;
        m1_mosi.rd_addr_valid = 1'b0;
        s_miso.rd_valid       = 1'b0;
        cyc();

        // ---------------- drain ----------------
        check("end_q_s_rd_addr", q_s_rd_addr.size(), 0);
        check("end_q_s_wr_addr", q_s_wr_addr.size(), 0);
        check("end_q_s_wr_data", q_s_wr_data.size(), 0);
        check("end_q_m0_rd",     q_m0_rd.size(), 0);
        check("end_q_m1_rd",     q_m1_rd.size(), 0);
        check("end_q_m0_wresp",  q_m0_wresp.size(), 0);
        check("end_q_m1_wresp",  q_m1_wresp.size(), 0);
        check("end_arb_err",     32'(arb_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
